ctrl_time_sched: RTL and testbench
==================================

# ctrl_time_sched

Parametrised event-time sequencer for the switching-control path. It compares the shared simulation-step `counter` against a programmable table of up to `N_EVT` event times. At each due event it drives the output bus `y` to that event's value and advances to the next table entry. It is the successor to the fixed 12-event/1-bit time controllers, adding configurable width, a configurable active-event count, start/done handshaking and order checking.

## Interface
- `N_EVT`, 12: table depth (1..64).
- `CW`, 12: counter/time width.
- `VW`, 1: value (output) width.
- `INIT`, 0: `VW`-bit value on `y` before the first event.
- `clk` in 1: system clock.
- `sta_n` in 1: reset; synchronous, active-low.
- `start` in 1: one-cycle pulse; re-arms the sequence.
- `en` in 1: when low, the FSM and all outputs hold.
- `counter` in CW: current step count, driven externally.
- `n_evt` in clog2(N_EVT+1): number of active table entries, sampled at `start`.
- `time_flat` in N_EVT*CW: entry k occupies `[k*CW +: CW]`.
- `value_flat` in N_EVT*VW: entry k occupies `[k*VW +: VW]`.
- `y` out VW: registered output value.
- `evt_pulse` out 1: high for one cycle when `y` has just been updated by an event.
- `evt_idx` out clog2(N_EVT): index of the next pending entry.
- `done` out 1: all active entries consumed. Never asserted when `CTRL_TIME_WRAP_EN` is defined.
- `err_order` out 1: sticky; set when the table is out of order.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: the FSM compares only entry `evt_idx`. The table must be ascending in time.
  - DONE: holds `y`.
- Reset (`sta_n`=0 at an edge):
  - state=IDLE, `y`=INIT, `evt_idx`=0, `evt_pulse`=0, `done`=0, `err_order`=0.
- `start` in any state:
  - `evt_idx`←0, `y`←INIT, `done`←0, `err_order`←0, latch `n_evt`.
  - Next state is RUN, or DONE if the latched `n_evt`=0.
- Match condition in RUN: `counter == time[evt_idx] − 1`, subtraction modulo 2^CW.
  - A time of 0 therefore matches at `counter` = 2^CW−1.
- On a match edge:
  - `y`←value[evt_idx], `evt_pulse`←1, `evt_idx`←`evt_idx`+1.
  - If the consumed index is `n_evt`−1, the FSM goes to DONE and sets `done`.
- Only one event can fire per cycle.
  - Duplicate times fire on consecutive matches, so effectively only the first of a run of duplicates fires at that count.
  - The others wait for the next time `counter` reaches that value.
- `err_order` is set on a match when time[evt_idx] ≤ the time of the previously fired entry. This check does not apply to entry 0.
- Priority: `sta_n` > `start` > `en` = 0 > match.
- `n_evt` > `N_EVT` is clamped to `N_EVT`.
- `time_flat` and `value_flat` may change during RUN. Only the entry currently indexed matters.

## Timing
- Match detected in cycle t (`counter` = T−1): `y`=value and `evt_pulse`=1 in cycle t+1, which is when `counter` = T.
- Compare-to-output latency is 1 cycle with no pipeline bubble. Back-to-back events at T and T+1 both fire.
- After `start` at edge e, the FSM is in RUN at e+1. A match is possible in the first RUN cycle.
- `done` rises in the same cycle as the final `evt_pulse`.
- A mid-RUN `start` aborts the sequence cleanly. No `evt_pulse` occurs on that edge.

## Configuration
- `CTRL_TIME_WRAP_EN` defined:
  - After the last active entry fires, `evt_idx`←0 and the FSM stays in RUN, giving a periodic waveform across `counter` wrap-around.
  - `y` is not reset to INIT on wrap. `done` stays 0.
  - The `err_order` check is skipped for the entry 0 that follows a wrap.
- `CTRL_TIME_WRAP_EN` undefined: behaviour as in Operation (DONE holds `y`).

## Structure
- Package `ctrl_time_pkg` holds:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the `clog2` helper function;
  - default parameter constants.
- Sub-module `muxer_n_math`: a parametrised N×VW select with a registered output and load enable. It generalises the fixed 12-input muxer. The top level owns the FSM, comparator and error logic.

## Test plan
- Reset, then wait 20 cycles without `start` → `y`=INIT, `evt_idx`=0, `done`=0, no `evt_pulse`.
- `N_EVT`=12, `VW`=1, times 5,10,…,60, values alternating 1/0, `n_evt`=12, counter ramps 0..70 → `y` toggles when `counter`=5,10,…,60; 12 pulses; `done` set in the cycle `counter`=60.
- `VW`=8, times 3,4 (adjacent), values 0xA5,0x5A, `n_evt`=2 → `y`=0xA5 when `counter`=3, 0x5A when `counter`=4, two consecutive pulses.
- Times 10,8, `n_evt`=2, counter ramps 0..4095 and wraps → first event fires at 10; second fires at 8 after the wrap and sets `err_order`=1.
- Mid-RUN `start` after 3 of 6 events → `y`=INIT, `evt_idx`=0; the sequence replays from entry 0. In the same test, `n_evt`=0 → DONE immediately, `y`=INIT.
- With `CTRL_TIME_WRAP_EN`, times 100,200, counter free-running over 3 wraps → 6 pulses, `done`=0, `y` period 4096 cycles.

Source files
------------

// File: rtl/ctrl_time_sched_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_time_pkg: shared state encoding, clog2 helper and defaults. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ctrl_time_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N_EVT = 12;
  localparam int DEF_CW    = 12;
  localparam int DEF_VW    = 1;

  // Never returns 0 so that single-entry tables still get a 1-bit index.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_time_sched_muxer_n_math.sv
// ---------------------------------------------------------------------------
// muxer_n_math: N x VW registered select with load and clear-to-INIT. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muxer_n_math
  import ctrl_time_pkg::*;
#(
  parameter int             N    = DEF_N_EVT,
  parameter int             VW   = DEF_VW,
  parameter logic [VW-1:0]  INIT = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [clog2(N)-1:0]   sel,
  input  logic [N*VW-1:0]       data_flat,
  output logic [VW-1:0]         q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= INIT;
    end else if (clr) begin
      q <= INIT;
    end else if (load) begin
      q <= data_flat[sel*VW +: VW];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ctrl_time_sched.sv
// ---------------------------------------------------------------------------
// ctrl_time_sched: event-time sequencer; CTRL_TIME_WRAP_EN makes it periodic.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ctrl_time_sched
  import ctrl_time_pkg::*;
#(
  parameter int             N_EVT = DEF_N_EVT,
  parameter int             CW    = DEF_CW,
  parameter int             VW    = DEF_VW,
  parameter logic [VW-1:0]  INIT  = '0
) (
  input  logic                        clk,
  input  logic                        sta_n,
  input  logic                        start,
  input  logic                        en,
  input  logic [CW-1:0]               counter,
  input  logic [clog2(N_EVT+1)-1:0]   n_evt,
  input  logic [N_EVT*CW-1:0]         time_flat,
  input  logic [N_EVT*VW-1:0]         value_flat,
  output logic [VW-1:0]               y,
  output logic                        evt_pulse,
  output logic [clog2(N_EVT)-1:0]     evt_idx,
  output logic                        done,
  output logic                        err_order
);

  localparam int IW = clog2(N_EVT);
  localparam int NW = clog2(N_EVT + 1);

  state_t          state;
  logic [NW-1:0]   n_lat;
  logic [CW-1:0]   prev_time;

  logic [IW-1:0]   sel;
  logic [CW-1:0]   cur_time;
  logic [NW-1:0]   n_clamp;
  logic            match;
  logic            last;
  logic            order_bad;
  logic            load;

  // After the final entry evt_idx may point one past the table; keep the
  // select in range since nothing is compared outside RUN anyway.
  assign sel       = (int'(evt_idx) < N_EVT) ? evt_idx : '0;
  assign cur_time  = time_flat[sel*CW +: CW];
  assign n_clamp   = (n_evt > NW'(N_EVT)) ? NW'(N_EVT) : n_evt;
  assign match     = (state == RUN) && (counter == (cur_time - CW'(1)));
  assign last      = (NW'(evt_idx) == (n_lat - NW'(1)));
  assign order_bad = (evt_idx != '0) && (cur_time <= prev_time);
  assign load      = en && !start && match;

  muxer_n_math #(
    .N    (N_EVT),
    .VW   (VW),
    .INIT (INIT)
  ) u_mux (
    .clk       (clk),
    .rst_n     (sta_n),
    .clr       (start),
    .load      (load),
    .sel       (sel),
    .data_flat (value_flat),
    .q         (y)
  );

  always_ff @(posedge clk) begin
    if (!sta_n) begin
      state     <= IDLE;
      evt_idx   <= '0;
      evt_pulse <= 1'b0;
      done      <= 1'b0;
      err_order <= 1'b0;
      n_lat     <= '0;
      prev_time <= '0;
    end else if (start) begin
      evt_idx   <= '0;
      evt_pulse <= 1'b0;
      done      <= 1'b0;
      err_order <= 1'b0;
      n_lat     <= n_clamp;
      state     <= (n_clamp == '0) ? DONE : RUN;
    end else if (en) begin
      evt_pulse <= 1'b0;
      if (match) begin
        evt_pulse <= 1'b1;
        prev_time <= cur_time;
        if (order_bad) err_order <= 1'b1;
        if (last) begin
`ifdef CTRL_TIME_WRAP_EN
          evt_idx <= '0;
`else
          evt_idx <= evt_idx + 1'b1;
          state   <= DONE;
          done    <= 1'b1;
`endif
        end else begin
          evt_idx <= evt_idx + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_time_sched.sv
// ---------------------------------------------------------------------------
// tb_ctrl_time_sched: scoreboard bench for ctrl_time_sched. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ctrl_time_sched;
  import ctrl_time_pkg::*;

  localparam int            N    = 12;
  localparam int            CW   = 12;
  localparam int            VW   = 8;
  localparam int            NW   = clog2(N + 1);
  localparam int            IW   = clog2(N);
  localparam logic [VW-1:0] INIT = 8'h3C;

  logic              clk;
  logic              sta_n;
  logic              start;
  logic              en;
  logic [CW-1:0]     counter;
  logic [NW-1:0]     n_evt;
  logic [N*CW-1:0]   time_flat;
  logic [N*VW-1:0]   value_flat;
  logic [VW-1:0]     y;
  logic              evt_pulse;
  logic [IW-1:0]     evt_idx;
  logic              done;
  logic              err_order;

  ctrl_time_sched #(.N_EVT(N), .CW(CW), .VW(VW), .INIT(INIT)) dut (
    .clk        (clk),
    .sta_n      (sta_n),
    .start      (start),
    .en         (en),
    .counter    (counter),
    .n_evt      (n_evt),
    .time_flat  (time_flat),
    .value_flat (value_flat),
    .y          (y),
    .evt_pulse  (evt_pulse),
    .evt_idx    (evt_idx),
    .done       (done),
    .err_order  (err_order)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] y;
    logic [IW-1:0] idx;
    logic          done;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  int   pulses = 0;

  // reference model state
  int            m_k, m_n;
  bit            m_run, m_done, m_err;
  logic [CW-1:0] m_prev;
  logic [VW-1:0] m_y;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sta_n === 1'b1 && evt_pulse === 1'b1) begin
      exp_t e;
      pulses = pulses + 1;
      total  = total + 1;
      if (q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_pulse cyc=%0d y=%h idx=%0d", cyc, y, evt_idx);
      end else begin
        e = q.pop_front();
        if (y !== e.y || evt_idx !== e.idx || done !== e.done || cyc != e.cyc)
        begin
          bad = bad + 1;
          $display("FAIL pulse got y=%h idx=%0d done=%b cyc=%0d exp y=%h idx=%0d done=%b cyc=%0d",
                   y, evt_idx, done, cyc, e.y, e.idx, e.done, e.cyc);
        end
      end
    end
  end

  // Inputs for the coming edge are set here, then one edge is taken.
  task automatic drive_cycle(input logic [CW-1:0] c, input logic e);
    logic [CW-1:0] tk;
    start   = 1'b0;
    en      = e;
    counter = c;
    if (m_run && e) begin
      tk = time_flat[m_k*CW +: CW];
      if (c == tk - CW'(1)) begin
        if (m_k != 0 && tk <= m_prev) m_err = 1'b1;
        m_prev = tk;
        m_y    = value_flat[m_k*VW +: VW];
        if (m_k == m_n - 1) begin
`ifdef CTRL_TIME_WRAP_EN
          m_k = 0;
`else
          m_k    = m_k + 1;
          m_run  = 1'b0;
          m_done = 1'b1;
`endif
        end else begin
          m_k = m_k + 1;
        end
        q.push_back('{y: m_y, idx: IW'(m_k), done: m_done, cyc: cyc + 1});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic ramp(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) drive_cycle(CW'(c), 1'b1);
  endtask

  task automatic do_start(input int n, input logic [CW-1:0] c);
    start   = 1'b1;
    en      = 1'b1;
    n_evt   = NW'(n);
    counter = c;
    m_k     = 0;
    m_n     = (n > N) ? N : n;
    m_run   = (m_n != 0);
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_y     = INIT;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    sta_n = 1'b0;
    m_run = 1'b0; m_k = 0; m_done = 1'b0; m_err = 1'b0; m_y = INIT;
    for (int k = 0; k < N; k++) begin
      time_flat[k*CW +: CW]  = CW'(5);
      value_flat[k*VW +: VW] = 8'hFF;
    end
    n_evt = NW'(N);
    drive_cycle(CW'(0), 1'b1);
    drive_cycle(CW'(4), 1'b1);
    total++;
    if (y !== INIT || evt_idx !== '0 || done !== 1'b0 || err_order !== 1'b0 || evt_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reset_state y=%h idx=%0d done=%b err=%b pulse=%b exp y=%h rest 0",
               y, evt_idx, done, err_order, evt_pulse, INIT);
    end
    sta_n = 1'b1;
    ramp(0, 19);
    settle();
    total++;
    if (y !== INIT || evt_idx !== '0 || done !== 1'b0 || evt_pulse !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_start y=%h idx=%0d done=%b pulse=%b exp y=%h idx=0 done=0",
               y, evt_idx, done, evt_pulse, INIT);
    end
  endtask

  task automatic test_toggle(input int n);
    int p0;
    for (int k = 0; k < N; k++) begin
      time_flat[k*CW +: CW]  = CW'(5 * (k + 1));
      value_flat[k*VW +: VW] = (k % 2 == 0) ? 8'h01 : 8'h00;
    end
    p0 = pulses;
    do_start(n, CW'(0));
    ramp(0, 70);
    settle();
    total++;
    if (pulses - p0 != 12 || q.size() != 0) begin
      bad++;
      $display("FAIL toggle_count n=%0d pulses=%0d pending=%0d exp pulses=12 pending=0",
               n, pulses - p0, q.size());
    end
    total++;
    if (y !== m_y || done !== m_done || err_order !== 1'b0 || evt_idx !== IW'(m_k)) begin
      bad++;
      $display("FAIL toggle_end y=%h done=%b err=%b idx=%0d exp y=%h done=%b err=0 idx=%0d",
               y, done, err_order, evt_idx, m_y, m_done, m_k);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    time_flat[0*CW +: CW]  = CW'(3);
    time_flat[1*CW +: CW]  = CW'(4);
    value_flat[0*VW +: VW] = 8'hA5;
    value_flat[1*VW +: VW] = 8'h5A;
    p0 = pulses;
    do_start(2, CW'(0));
    ramp(0, 8);
    settle();
    total++;
    if (pulses - p0 != 2 || q.size() != 0 || y !== 8'h5A || done !== m_done) begin
      bad++;
      $display("FAIL back_to_back pulses=%0d pending=%0d y=%h done=%b exp 2 0 5a %b",
               pulses - p0, q.size(), y, done, m_done);
    end
  endtask

  task automatic test_order();
    time_flat[0*CW +: CW]  = CW'(10);
    time_flat[1*CW +: CW]  = CW'(8);
    value_flat[0*VW +: VW] = 8'h77;
    value_flat[1*VW +: VW] = 8'h88;
    do_start(2, CW'(0));
    ramp(0, 20);
    settle();
    total++;
    if (y !== 8'h77 || err_order !== 1'b0 || evt_idx !== IW'(1)) begin
      bad++;
      $display("FAIL order_first y=%h err=%b idx=%0d exp y=77 err=0 idx=1", y, err_order, evt_idx);
    end
    ramp(21, 4095);
    ramp(0, 12);
    settle();
    total++;
    if (y !== 8'h88 || err_order !== 1'b1 || m_err !== 1'b1 || done !== m_done || q.size() != 0) begin
      bad++;
      $display("FAIL order_err y=%h err=%b done=%b pending=%0d exp y=88 err=1 done=%b",
               y, err_order, done, q.size(), m_done);
    end
  endtask

  task automatic test_enable();
    time_flat[0*CW +: CW]  = CW'(5);
    time_flat[1*CW +: CW]  = CW'(10);
    value_flat[0*VW +: VW] = 8'h12;
    value_flat[1*VW +: VW] = 8'h34;
    do_start(2, CW'(0));
    ramp(0, 3);
    drive_cycle(CW'(4), 1'b0);
    ramp(5, 12);
    settle();
    total++;
    if (y !== INIT || evt_idx !== '0 || q.size() != 0) begin
      bad++;
      $display("FAIL enable_hold y=%h idx=%0d exp y=%h idx=0", y, evt_idx, INIT);
    end
    drive_cycle(CW'(4), 1'b1);
    drive_cycle(CW'(5), 1'b1);
    settle();
    total++;
    if (y !== 8'h12 || evt_idx !== IW'(1) || q.size() != 0) begin
      bad++;
      $display("FAIL enable_resume y=%h idx=%0d exp y=12 idx=1", y, evt_idx);
    end
  endtask

  task automatic test_restart();
    int p0;
    for (int k = 0; k < 6; k++) begin
      time_flat[k*CW +: CW]  = CW'(10 * (k + 1));
      value_flat[k*VW +: VW] = 8'h40 + VW'(k);
    end
    do_start(6, CW'(0));
    ramp(1, 35);
    settle();
    total++;
    if (y !== 8'h42 || evt_idx !== IW'(3)) begin
      bad++;
      $display("FAIL restart_pre y=%h idx=%0d exp y=42 idx=3", y, evt_idx);
    end
    // counter 39 would match entry 3 were start not taking priority
    do_start(6, CW'(39));
    total++;
    if (y !== INIT || evt_idx !== '0 || evt_pulse !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL restart_abort y=%h idx=%0d pulse=%b done=%b exp y=%h idx=0 pulse=0 done=0",
               y, evt_idx, evt_pulse, done, INIT);
    end
    p0 = pulses;
    ramp(0, 70);
    settle();
    total++;
    if (pulses - p0 != 6 || y !== 8'h45 || done !== m_done || q.size() != 0) begin
      bad++;
      $display("FAIL restart_replay pulses=%0d y=%h done=%b exp 6 45 %b", pulses - p0, y, done, m_done);
    end
    do_start(0, CW'(9));
    total++;
    if (y !== INIT || evt_idx !== '0 || evt_pulse !== 1'b0) begin
      bad++;
      $display("FAIL zero_evt y=%h idx=%0d pulse=%b exp y=%h idx=0 pulse=0", y, evt_idx, evt_pulse, INIT);
    end
    p0 = pulses;
    ramp(0, 20);
    settle();
    total++;
    if (pulses != p0 || y !== INIT) begin
      bad++;
      $display("FAIL zero_evt_hold pulses=%0d y=%h exp 0 %h", pulses - p0, y, INIT);
    end
  endtask

`ifdef CTRL_TIME_WRAP_EN
  task automatic test_wrap();
    int p0;
    time_flat[0*CW +: CW]  = CW'(100);
    time_flat[1*CW +: CW]  = CW'(200);
    value_flat[0*VW +: VW] = 8'h11;
    value_flat[1*VW +: VW] = 8'h22;
    p0 = pulses;
    do_start(2, CW'(0));
    for (int w = 0; w < 3; w++) ramp(0, 4095);
    settle();
    total++;
    if (pulses - p0 != 6 || done !== 1'b0 || err_order !== 1'b0 || q.size() != 0) begin
      bad++;
      $display("FAIL wrap pulses=%0d done=%b err=%b exp 6 0 0", pulses - p0, done, err_order);
    end
  endtask
`endif

  initial begin
    sta_n      = 1'b0;
    start      = 1'b0;
    en         = 1'b1;
    counter    = '0;
    n_evt      = '0;
    time_flat  = '0;
    value_flat = '0;
    @(posedge clk); #1;
    test_reset();
    test_toggle(12);
    test_toggle(15);
    test_back_to_back();
    test_order();
    test_enable();
    test_restart();
`ifdef CTRL_TIME_WRAP_EN
    test_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
